sqrt_arbiter: RTL
=================

Name: sqrt_arbiter

Overview:
- Shares one sequential square-root engine between NREQ requesters.
- Each requester has an independent valid/ready request channel (operand) and response channel (root).
- Arbitrates, issues one operand at a time to the engine, captures the engine result, and returns it to the requester that issued it.
- Sits between client blocks and a single sqrt engine instance; only one operation is in flight at a time.

Parameters:
- N, 16, operand width in bits; must be even; root width is N/2.
- NREQ, 4, number of requesters; range 2..8.
- IDW, $clog2(NREQ), width of the internal requester index (localparam).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_vld  in  NREQ  per-requester operand valid
- req_rdy  out  NREQ  per-requester operand accept; at most one bit set
- req_num  in  NREQ*N  packed operands; requester i occupies bits [i*N +: N]
- rsp_vld  out  NREQ  per-requester result valid; at most one bit set
- rsp_rdy  in  NREQ  per-requester result ready
- rsp_res  out  N/2  result, shared by all requesters; meaningful only where rsp_vld is set
- sq_vld  out  1  operand valid to engine
- sq_rdy  in  1  engine accepts operand
- sq_num  out  N  operand to engine
- sq_res_vld  in  1  engine result valid
- sq_res_rdy  out  1  arbiter accepts engine result
- sq_res  in  N/2  engine result
- busy  out  1  high in any state other than IDLE
- proto_err  out  1  sticky; set when sq_res_vld is seen outside WAIT

Behaviour:
- Reset (reset_n=0 at a clk edge, allowed at any time including mid-operation):
  - state goes to IDLE; every output goes to 0.
  - Latched operand, latched index, latched result, round-robin pointer and proto_err clear to 0.
  - An operation in flight is abandoned; a late engine result is not forwarded.
- All outputs are decoded from registers, except req_rdy, which is combinational from state, req_vld and the pointer.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is chosen among the set req_vld bits by the arbitration rule (see Optional Feature).
  - req_rdy[winner]=1 in the same cycle. On that edge: latch req_num slice and winner index, go to ISSUE.
  - With no req_vld set, stay in IDLE and hold all req_rdy at 0.
- ISSUE: sq_vld=1, sq_num=latched operand. When sq_rdy=1: go to WAIT. sq_vld holds until accepted.
- WAIT: sq_res_rdy=1. When sq_res_vld=1: latch sq_res, go to RESP.
- RESP:
  - rsp_vld[latched index]=1 and rsp_res=latched result, held stable until accepted.
  - When rsp_rdy[latched index]=1: go to IDLE and update the pointer.
  - rsp_rdy bits of other requesters are ignored.
- Minimum cycle count, accept to rsp_vld: 3 cycles plus the engine latency (IDLE→ISSUE, ISSUE→WAIT, WAIT→RESP).
- Back-to-back: a new request can be accepted in the first IDLE cycle after a response handshake. There is no IDLE bypass.
- A requester may deassert req_vld before it is granted; it is then simply not selected.
- A winner whose req_vld is high is always accepted in IDLE, so the grant decision cannot change within a cycle.
- sq_res_vld in IDLE, ISSUE or RESP:
  - set proto_err (stays set until reset), ignore the data, no state change.
- Illegal state encoding: go to IDLE.

Optional Feature:
- Macro: SQRT_ARB_RR_EN.
- Defined (round-robin):
  - Arbitration is round-robin starting at the pointer.
  - The pointer is updated to (latched index + 1) mod NREQ on each response handshake.
  - No requester waits more than NREQ-1 operations.
- Undefined (fixed priority):
  - Lowest set index wins.
  - The pointer register is not implemented.

Test Plan:
- Single requester: req 2 sends num=144; engine model returns 12 after 8 cycles → rsp_vld=4'b0100, rsp_res=12, held until rsp_rdy[2]; proto_err=0.
- All four assert at once with num=16, 25, 36, 49.
  - RR_EN: responses return in order 0,1,2,3 with 4, 5, 6, 7; a second burst starts with requester 0 again after requester 3.
  - Without RR_EN: requester 0 repeatedly re-requesting starves requester 1.
- Backpressure: sq_rdy held 0 for 5 cycles in ISSUE → sq_vld and sq_num=0xFFFF stay stable; rsp_rdy held 0 for 4 cycles in RESP → rsp_res=255 stays stable; no new req_rdy during either stall.
- Wrong-requester ready: the RESP owner is requester 1; only rsp_rdy[3]=1 → state stays RESP and rsp_vld stays 4'b0010.
- Spurious engine result: sq_res_vld=1 while in IDLE → proto_err=1 and stays 1; the next normal operation still completes correctly.
- Reset mid-WAIT: reset_n=0 for one cycle → all outputs 0, busy=0; the engine result arriving afterwards is ignored and no rsp_vld is asserted.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// Shares one sequential sqrt engine between NREQ valid/ready requesters; SQRT_ARB_RR_EN selects round-robin, otherwise fixed priority.
// Latency accept->rsp_vld = 3 cycles + engine latency; req_rdy is held low while any operation is in flight.
module sqrt_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_vld,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*N-1:0] req_num,
    output logic [NREQ-1:0]   rsp_vld,
    input  logic [NREQ-1:0]   rsp_rdy,
    output logic [N/2-1:0]    rsp_res,
    output logic              sq_vld,
    input  logic              sq_rdy,
    output logic [N-1:0]      sq_num,
    input  logic              sq_res_vld,
    output logic              sq_res_rdy,
    input  logic [N/2-1:0]    sq_res,
    output logic              busy,
    output logic              proto_err
);
    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   num_q, num_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic [N/2-1:0] res_q, res_d;
    logic           proto_err_q, proto_err_d;
    logic           win_vld;
    logic [IDW-1:0] win_idx;

`ifdef SQRT_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;
`endif

    // Scan from the highest offset down so the lowest offset from the start point wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            logic [IDW-1:0] sel;
`ifdef SQRT_ARB_RR_EN
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
`else
            j = k;
`endif
            sel = IDW'(j);
            if (req_vld[sel]) begin
                win_vld = 1'b1;
                win_idx = sel;
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (state_q == IDLE && win_vld) req_rdy[win_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        idx_d       = idx_q;
        res_d       = res_q;
        proto_err_d = proto_err_q | (sq_res_vld && state_q != WAIT);
`ifdef SQRT_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    num_d   = req_num[win_idx*N +: N];
                    idx_d   = win_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sq_rdy) state_d = WAIT;
            end
            WAIT: begin
                if (sq_res_vld) begin
                    res_d   = sq_res;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_rdy[idx_q]) begin
                    state_d = IDLE;
`ifdef SQRT_ARB_RR_EN
                    ptr_d   = (idx_q == IDW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            idx_q       <= '0;
            res_q       <= '0;
            proto_err_q <= 1'b0;
`ifdef SQRT_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            proto_err_q <= proto_err_d;
`ifdef SQRT_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    always_comb begin
        rsp_vld = '0;
        if (state_q == RESP) rsp_vld[idx_q] = 1'b1;
    end

    assign rsp_res    = res_q;
    assign sq_vld     = (state_q == ISSUE);
    assign sq_num     = num_q;
    assign sq_res_rdy = (state_q == WAIT);
    assign busy       = (state_q != IDLE);
    assign proto_err  = proto_err_q;
endmodule
